spike_encoder: RTL and testbench

Parametrised pixel-to-spike encoder for the SNN input layer, running in a single clock domain. It accepts one frame of NUM_CH pixels through a valid/ready handshake and then emits a spike vector once per timestep, for WINDOW timesteps. Timesteps are advanced by a step_en strobe. Three encoding modes are supported: deterministic rate, stochastic rate (LFSR), and time-to-first-spike (TTFS). Spike vectors feed the first hidden-layer neuron array.

---
 rtl/spike_encoder.sv | 166 ++++++++++++++++
 tb/tb_spike_encoder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : spike_encoder
// Purpose  : Pixel-to-spike encoder for the SNN input layer. Accepts one
//            frame of NUM_CH pixels, then emits one spike vector per step_en
//            for WINDOW timesteps using rate, stochastic (LFSR) or
//            time-to-first-spike encoding.
// Revision : 1.0 - initial release
// ============================================================================
module spike_encoder #(
  parameter int          NUM_CH  = 16,
  parameter int          PIXEL_W = 8,
  parameter int          WINDOW  = 32,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [1:0]                  mode,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  input  logic [NUM_CH*PIXEL_W-1:0]   pix_data,
  input  logic                        step_en,
  input  logic                        flush,
  output logic [NUM_CH-1:0]           spike_out,
  output logic                        spike_valid,
  output logic [$clog2(WINDOW)-1:0]   step_idx,
  output logic                        window_done,
  output logic                        busy
);

  // Timestep counter width, threshold width (one extra bit so WINDOW fits)
  // and the full-precision width of pix*WINDOW + rounding term.
  localparam int c_cnt_w  = $clog2(WINDOW);
  localparam int c_thr_w  = c_cnt_w + 1;
  localparam int c_prod_w = PIXEL_W + c_thr_w;

  localparam logic [c_cnt_w-1:0]  c_last   = c_cnt_w'(WINDOW - 1);
  localparam logic [c_thr_w-1:0]  c_window = c_thr_w'(WINDOW);
  localparam logic [c_prod_w-1:0] c_win_p  = c_prod_w'(WINDOW);
  localparam logic [c_prod_w-1:0] c_half   = c_prod_w'(2 ** (PIXEL_W - 1));

  // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
  localparam logic [15:0] c_lfsr_taps = 16'hB400;

  localparam logic [1:0] c_mode_stoch = 2'd1;
  localparam logic [1:0] c_mode_ttfs  = 2'd2;

  localparam logic c_st_idle = 1'b0;
  localparam logic c_st_run  = 1'b1;

  logic                        r_state;
  logic                        w_state_next;
  logic                        w_accept;
  logic                        w_step;
  logic                        w_last;
  logic [c_cnt_w-1:0]          r_t;
  logic [15:0]                 r_lfsr;
  logic [15:0]                 w_lfsr_next;
  logic [1:0]                  r_mode;
  logic [NUM_CH*PIXEL_W-1:0]   r_pix;
  logic [NUM_CH*c_thr_w-1:0]   r_thr;
  logic [NUM_CH*c_thr_w-1:0]   w_thr_new;
  logic [NUM_CH-1:0]           w_spike;

  // A frame is taken only through the ready handshake; flush blocks it via pix_ready.
  assign w_accept = pix_valid && pix_ready;
  // A timestep is consumed only while running and not being flushed.
  assign w_step   = (r_state == c_st_run) && step_en && !flush;
  assign w_last   = (r_t == c_last);

  assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_lfsr_taps) : (r_lfsr >> 1);

  // Per-channel threshold computation for the incoming frame and spike decision
  // for the latched frame.
  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      localparam int c_rot = i % 16;

      logic [PIXEL_W-1:0] w_pix_in;
      logic [PIXEL_W-1:0] w_pix;
      logic [PIXEL_W-1:0] w_rnd;
      logic [c_thr_w-1:0] w_thr;
      logic               w_rate;
      logic               w_stoch;
      logic               w_ttfs;

      assign w_pix_in = pix_data[i*PIXEL_W +: PIXEL_W];
      // Rounded scale of the pixel onto 0..WINDOW; full-width product, no truncation.
      assign w_thr_new[i*c_thr_w +: c_thr_w] =
        c_thr_w'((c_prod_w'(w_pix_in) * c_win_p + c_half) >> PIXEL_W);

      assign w_pix = r_pix[i*PIXEL_W +: PIXEL_W];
      assign w_thr = r_thr[i*c_thr_w +: c_thr_w];
      // Each channel sees the pre-shift LFSR rotated left by its index.
      assign w_rnd = PIXEL_W'((r_lfsr << c_rot) | (r_lfsr >> (16 - c_rot)));

      assign w_rate  = ({1'b0, r_t} < w_thr);
      assign w_stoch = (w_pix > w_rnd);
      assign w_ttfs  = (w_thr != '0) && ({1'b0, r_t} == (c_window - w_thr));

      assign w_spike[i] = (r_mode == c_mode_stoch) ? w_stoch :
                          (r_mode == c_mode_ttfs)  ? w_ttfs  : w_rate;
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state: leave IDLE on accept, leave RUN on flush or on the final step.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle: if (w_accept) w_state_next = c_st_run;
      c_st_run:  if (flush || (step_en && w_last)) w_state_next = c_st_idle;
      default:   w_state_next = c_st_idle;
    endcase
  end

  // State-derived outputs; ready is withheld during reset and flush.
  always_comb begin
    pix_ready = (r_state == c_st_idle) && rst_n && !flush;
    busy      = (r_state == c_st_run);
  end

  // Frame capture, timestep counter, LFSR and registered spike outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_t         <= '0;
      r_lfsr      <= SEED;
      r_mode      <= '0;
      r_pix       <= '0;
      r_thr       <= '0;
      spike_out   <= '0;
      spike_valid <= 1'b0;
      step_idx    <= '0;
      window_done <= 1'b0;
    end else begin
      spike_out   <= '0;
      spike_valid <= 1'b0;
      window_done <= 1'b0;
      if (flush) begin
        r_t <= '0;
      end else if (w_accept) begin
        r_pix  <= pix_data;
        r_mode <= mode;
        r_thr  <= w_thr_new;
        r_t    <= '0;
      end else if (w_step) begin
        spike_out   <= w_spike;
        spike_valid <= 1'b1;
        step_idx    <= r_t;
        window_done <= w_last;
        r_t         <= w_last ? '0 : r_t + 1'b1;
        r_lfsr      <= w_lfsr_next;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spike_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_spike_encoder
// Purpose  : Self-checking bench for spike_encoder against a behavioural
//            frame/timestep model with randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spike_encoder;

  localparam int          NUM_CH  = 4;
  localparam int          PIXEL_W = 8;
  localparam int          WINDOW  = 32;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          CW      = $clog2(WINDOW);

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic [1:0]                mode = '0;
  logic                      pix_valid = 1'b0;
  logic                      pix_ready;
  logic [NUM_CH*PIXEL_W-1:0] pix_data = '0;
  logic                      step_en = 1'b0;
  logic                      flush = 1'b0;
  logic [NUM_CH-1:0]         spike_out;
  logic                      spike_valid;
  logic [CW-1:0]             step_idx;
  logic                      window_done;
  logic                      busy;

  spike_encoder #(
    .NUM_CH (NUM_CH),
    .PIXEL_W(PIXEL_W),
    .WINDOW (WINDOW),
    .SEED   (SEED)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode       (mode),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_data   (pix_data),
    .step_en    (step_en),
    .flush      (flush),
    .spike_out  (spike_out),
    .spike_valid(spike_valid),
    .step_idx   (step_idx),
    .window_done(window_done),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: latched frame, step count, running flag, LFSR.
  int   m_pix[NUM_CH];
  int   m_mode = 0;
  int   m_t    = 0;
  bit   m_run  = 1'b0;
  int   m_lfsr = SEED;

  logic [NUM_CH-1:0] exp_spike = '0;
  logic              exp_valid = 1'b0;
  logic              exp_done  = 1'b0;
  logic [CW-1:0]     exp_idx   = '0;
  logic              exp_ready = 1'b0;
  logic              smp_ready = 1'b0;

  function automatic int thr_of(input int p);
    return (p * WINDOW + (1 << (PIXEL_W - 1))) >> PIXEL_W;
  endfunction

  function automatic int lfsr_step(input int x);
    if ((x & 1) != 0) return (x >> 1) ^ 32'hB400;
    return x >> 1;
  endfunction

  function automatic logic [NUM_CH-1:0] model_spikes(input int md, input int t, input int lf);
    logic [NUM_CH-1:0] s;
    int k, r, thr;
    s = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      thr = thr_of(m_pix[ch]);
      k   = ch % 16;
      r   = (((lf << k) | (lf >> (16 - k))) & 32'hFFFF) & ((1 << PIXEL_W) - 1);
      case (md)
        1:       s[ch] = (m_pix[ch] > r);
        2:       s[ch] = (thr != 0) && (t == WINDOW - thr);
        default: s[ch] = (t < thr);
      endcase
    end
    return s;
  endfunction

  function automatic logic [NUM_CH*PIXEL_W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {PIXEL_W'(d), PIXEL_W'(c), PIXEL_W'(b), PIXEL_W'(a)};
  endfunction

  function automatic logic [NUM_CH*PIXEL_W-1:0] rand_pix();
    logic [NUM_CH*PIXEL_W-1:0] v;
    int sel;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      sel = $urandom_range(0, 5);
      if (sel == 0)      v[ch*PIXEL_W +: PIXEL_W] = '0;
      else if (sel == 1) v[ch*PIXEL_W +: PIXEL_W] = '1;
      else               v[ch*PIXEL_W +: PIXEL_W] = PIXEL_W'($urandom_range(0, 255));
    end
    return v;
  endfunction

  // Apply one cycle of inputs, predict the outputs that follow the next edge,
  // then advance to 1 time unit after that edge.
  task automatic cyc(input logic rn, input logic v, input logic [NUM_CH*PIXEL_W-1:0] pd,
                     input logic [1:0] md, input logic se, input logic fl);
    rst_n = rn; pix_valid = v; pix_data = pd; mode = md; step_en = se; flush = fl;
    #1;
    smp_ready = pix_ready;
    exp_ready = rn && !m_run && !fl;
    exp_valid = 1'b0;
    exp_done  = 1'b0;
    exp_spike = '0;
    if (!rn) begin
      m_run = 1'b0; m_t = 0; m_lfsr = SEED; exp_idx = '0;
    end else if (fl) begin
      m_run = 1'b0; m_t = 0;
    end else if (!m_run) begin
      if (v) begin
        for (int ch = 0; ch < NUM_CH; ch++) m_pix[ch] = int'(pd[ch*PIXEL_W +: PIXEL_W]);
        m_mode = int'(md); m_run = 1'b1; m_t = 0;
      end
    end else if (se) begin
      exp_valid = 1'b1;
      exp_spike = model_spikes(m_mode, m_t, m_lfsr);
      exp_idx   = CW'(m_t);
      m_lfsr    = lfsr_step(m_lfsr);
      m_t++;
      if (m_t == WINDOW) begin
        exp_done = 1'b1; m_run = 1'b0; m_t = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, '0, 2'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, rand_pix(), 2'd1, 1'b1, 1'b0);
    checks++;
    if (spike_valid !== 1'b0 || window_done !== 1'b0 || busy !== 1'b0 || spike_out !== '0 ||
        step_idx !== '0 || smp_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: valid=%b done=%b busy=%b spike=%b idx=%0d ready=%b required all 0",
               spike_valid, window_done, busy, spike_out, step_idx, smp_ready);
    end
    cyc(1'b1, 1'b0, '0, 2'd0, 1'b1, 1'b0);
    checks++;
    if (smp_ready !== 1'b1 || spike_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_step_ignored: ready=%b valid=%b busy=%b required 1/0/0", smp_ready, spike_valid, busy);
    end
  endtask

  task automatic test_rate();
    int cnt[NUM_CH];
    int done_n, done_idx;
    for (int ch = 0; ch < NUM_CH; ch++) cnt[ch] = 0;
    done_n = 0; done_idx = -1;
    cyc(1'b1, 1'b1, pack4(0, 128, 255, 4), 2'd0, 1'b0, 1'b0);
    for (int s = 0; s <= WINDOW; s++) begin
      checks++;
      if (spike_valid !== exp_valid || spike_out !== exp_spike || window_done !== exp_done ||
          busy !== m_run || smp_ready !== exp_ready || (exp_valid && step_idx !== exp_idx)) begin
        failures++;
        $display("FAIL rate: valid=%b/%b spike=%b/%b done=%b/%b busy=%b/%b ready=%b/%b idx=%0d/%0d (actual/required)",
                 spike_valid, exp_valid, spike_out, exp_spike, window_done, exp_done, busy, m_run, smp_ready, exp_ready, step_idx, exp_idx);
      end
      for (int ch = 0; ch < NUM_CH; ch++) cnt[ch] += (spike_out[ch] === 1'b1) ? 1 : 0;
      if (window_done === 1'b1) begin
        done_n++; done_idx = int'(step_idx);
        checks++;
        if (pix_ready !== 1'b1) begin
          failures++;
          $display("FAIL rate_ready_on_done: pix_ready=%b required 1", pix_ready);
        end
      end
      if (s < WINDOW) cyc(1'b1, 1'b0, '0, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
    end
    checks++;
    if (cnt[0] != 0 || cnt[1] != 16 || cnt[2] != 32 || cnt[3] != 1) begin
      failures++;
      $display("FAIL rate_counts: got %0d %0d %0d %0d required 0 16 32 1", cnt[0], cnt[1], cnt[2], cnt[3]);
    end
    checks++;
    if (done_n != 1 || done_idx != WINDOW - 1) begin
      failures++;
      $display("FAIL rate_done: pulses=%0d idx=%0d required 1 at %0d", done_n, done_idx, WINDOW - 1);
    end
  endtask

  task automatic test_ttfs();
    int cnt[NUM_CH];
    int first[NUM_CH];
    for (int ch = 0; ch < NUM_CH; ch++) begin cnt[ch] = 0; first[ch] = -1; end
    cyc(1'b1, 1'b1, pack4(0, 128, 255, 4), 2'd2, 1'b0, 1'b0);
    for (int s = 0; s < WINDOW; s++) begin
      cyc(1'b1, 1'b0, '0, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
      checks++;
      if (spike_valid !== exp_valid || spike_out !== exp_spike || window_done !== exp_done ||
          busy !== m_run || smp_ready !== exp_ready || (exp_valid && step_idx !== exp_idx)) begin
        failures++;
        $display("FAIL ttfs: valid=%b/%b spike=%b/%b done=%b/%b busy=%b/%b ready=%b/%b idx=%0d/%0d (actual/required)",
                 spike_valid, exp_valid, spike_out, exp_spike, window_done, exp_done, busy, m_run, smp_ready, exp_ready, step_idx, exp_idx);
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (spike_out[ch] === 1'b1) begin
          cnt[ch]++;
          if (first[ch] < 0) first[ch] = int'(step_idx);
        end
      end
    end
    checks++;
    if (first[0] != -1 || first[1] != 16 || first[2] != 0 || first[3] != 31 ||
        cnt[0] != 0 || cnt[1] != 1 || cnt[2] != 1 || cnt[3] != 1) begin
      failures++;
      $display("FAIL ttfs_times: first=%0d %0d %0d %0d counts=%0d %0d %0d %0d required -1 16 0 31 / 0 1 1 1",
               first[0], first[1], first[2], first[3], cnt[0], cnt[1], cnt[2], cnt[3]);
    end
  endtask

  task automatic test_stochastic();
    int dut_cnt[NUM_CH];
    int mdl_cnt[NUM_CH];
    int gap;
    for (int ch = 0; ch < NUM_CH; ch++) begin dut_cnt[ch] = 0; mdl_cnt[ch] = 0; end
    for (int f = 0; f < 32; f++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cyc(1'b1, 1'b0, '0, 2'd1, 1'($urandom_range(0, 1)), 1'b0);
      cyc(1'b1, 1'b1, pack4(255, 255, 0, 255), 2'd1, 1'b0, 1'b0);
      for (int s = 0; s < WINDOW; s++) begin
        cyc(1'b1, 1'b0, '0, 2'd0, 1'b1, 1'b0);
        checks++;
        if (spike_valid !== exp_valid || spike_out !== exp_spike || window_done !== exp_done ||
            busy !== m_run || smp_ready !== exp_ready || (exp_valid && step_idx !== exp_idx)) begin
          failures++;
          $display("FAIL stoch: valid=%b/%b spike=%b/%b done=%b/%b busy=%b/%b ready=%b/%b idx=%0d/%0d (actual/required)",
                   spike_valid, exp_valid, spike_out, exp_spike, window_done, exp_done, busy, m_run, smp_ready, exp_ready, step_idx, exp_idx);
        end
        for (int ch = 0; ch < NUM_CH; ch++) begin
          dut_cnt[ch] += (spike_out[ch] === 1'b1) ? 1 : 0;
          mdl_cnt[ch] += int'(exp_spike[ch]);
        end
      end
    end
    checks++;
    if (dut_cnt[2] != 0) begin
      failures++;
      $display("FAIL stoch_zero_channel: count=%0d required 0", dut_cnt[2]);
    end
    checks++;
    if (dut_cnt[0] != mdl_cnt[0] || dut_cnt[1] != mdl_cnt[1] || dut_cnt[3] != mdl_cnt[3]) begin
      failures++;
      $display("FAIL stoch_counts: got %0d %0d %0d required %0d %0d %0d",
               dut_cnt[0], dut_cnt[1], dut_cnt[3], mdl_cnt[0], mdl_cnt[1], mdl_cnt[3]);
    end
  endtask

  task automatic test_sparse();
    logic [1:0] md;
    md = 2'($urandom_range(0, 3));
    cyc(1'b1, 1'b1, rand_pix(), md, 1'b0, 1'b0);
    for (int s = 0; s < WINDOW; s++) begin
      for (int g = 0; g < 5; g++) begin
        if (s == WINDOW - 1 && g > 0) break;
        cyc(1'b1, 1'b1, rand_pix(), 2'($urandom_range(0, 3)), (g == 0), 1'b0);
        checks++;
        if (spike_valid !== exp_valid || spike_out !== exp_spike || window_done !== exp_done ||
            busy !== m_run || smp_ready !== exp_ready || (exp_valid && step_idx !== exp_idx)) begin
          failures++;
          $display("FAIL sparse: valid=%b/%b spike=%b/%b done=%b/%b busy=%b/%b ready=%b/%b idx=%0d/%0d (actual/required)",
                   spike_valid, exp_valid, spike_out, exp_spike, window_done, exp_done, busy, m_run, smp_ready, exp_ready, step_idx, exp_idx);
        end
      end
    end
  endtask

  task automatic test_flush();
    cyc(1'b1, 1'b1, rand_pix(), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
    for (int s = 0; s < 14; s++) begin
      if (s < 10)       cyc(1'b1, 1'b0, '0, 2'd0, 1'b1, 1'b0);
      else if (s == 10) cyc(1'b1, 1'b1, rand_pix(), 2'd0, 1'b1, 1'b1);
      else if (s == 11) cyc(1'b1, 1'b0, '0, 2'd0, 1'b1, 1'b0);
      else if (s == 12) cyc(1'b1, 1'b1, rand_pix(), 2'($urandom_range(0, 3)), 1'b0, 1'b0);
      else              cyc(1'b1, 1'b0, '0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (spike_valid !== exp_valid || spike_out !== exp_spike || window_done !== exp_done ||
          busy !== m_run || smp_ready !== exp_ready || (exp_valid && step_idx !== exp_idx)) begin
        failures++;
        $display("FAIL flush_s%0d: valid=%b/%b spike=%b/%b done=%b/%b busy=%b/%b ready=%b/%b idx=%0d/%0d (actual/required)",
                 s, spike_valid, exp_valid, spike_out, exp_spike, window_done, exp_done, busy, m_run, smp_ready, exp_ready, step_idx, exp_idx);
      end
    end
    checks++;
    if (spike_valid !== 1'b1 || step_idx !== '0) begin
      failures++;
      $display("FAIL flush_restart_idx: valid=%b idx=%0d required 1 and 0", spike_valid, step_idx);
    end
    for (int s = 1; s < WINDOW; s++) cyc(1'b1, 1'b0, '0, 2'd0, 1'b1, 1'b0);
  endtask

  task automatic test_reset_midframe();
    cyc(1'b1, 1'b1, rand_pix(), 2'd1, 1'b0, 1'b0);
    for (int s = 0; s < 7; s++) cyc(1'b1, 1'b0, '0, 2'd0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, rand_pix(), 2'd1, 1'b1, 1'b0);
    checks++;
    if (spike_valid !== 1'b0 || window_done !== 1'b0 || busy !== 1'b0 || spike_out !== '0 ||
        step_idx !== '0 || smp_ready !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset: valid=%b done=%b busy=%b spike=%b idx=%0d ready=%b required all 0",
               spike_valid, window_done, busy, spike_out, step_idx, smp_ready);
    end
    cyc(1'b1, 1'b1, pack4(128, 64, 200, 255), 2'd1, 1'b0, 1'b0);
    for (int s = 0; s < WINDOW; s++) begin
      cyc(1'b1, 1'b0, '0, 2'd0, 1'b1, 1'b0);
      checks++;
      if (spike_valid !== exp_valid || spike_out !== exp_spike || window_done !== exp_done ||
          busy !== m_run || smp_ready !== exp_ready || (exp_valid && step_idx !== exp_idx)) begin
        failures++;
        $display("FAIL reseed: valid=%b/%b spike=%b/%b done=%b/%b busy=%b/%b ready=%b/%b idx=%0d/%0d (actual/required)",
                 spike_valid, exp_valid, spike_out, exp_spike, window_done, exp_done, busy, m_run, smp_ready, exp_ready, step_idx, exp_idx);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 4; f++) begin
      cyc(1'b1, 1'b1, rand_pix(), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      checks++;
      if (busy !== 1'b1 || smp_ready !== 1'b1) begin
        failures++;
        $display("FAIL b2b_no_bubble: busy=%b ready_at_accept=%b required 1/1", busy, smp_ready);
      end
      for (int s = 0; s < WINDOW; s++) begin
        cyc(1'b1, 1'b0, '0, 2'($urandom_range(0, 3)), 1'b1, 1'b0);
        checks++;
        if (spike_valid !== exp_valid || spike_out !== exp_spike || window_done !== exp_done ||
            busy !== m_run || smp_ready !== exp_ready || (exp_valid && step_idx !== exp_idx)) begin
          failures++;
          $display("FAIL b2b: valid=%b/%b spike=%b/%b done=%b/%b busy=%b/%b ready=%b/%b idx=%0d/%0d (actual/required)",
                   spike_valid, exp_valid, spike_out, exp_spike, window_done, exp_done, busy, m_run, smp_ready, exp_ready, step_idx, exp_idx);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 800; n++) begin
      cyc(1'($urandom_range(0, 199) != 0), 1'($urandom_range(0, 1)), rand_pix(),
          2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
      checks++;
      if (spike_valid !== exp_valid || spike_out !== exp_spike || window_done !== exp_done ||
          busy !== m_run || smp_ready !== exp_ready || (exp_valid && step_idx !== exp_idx)) begin
        failures++;
        $display("FAIL random_c%0d: valid=%b/%b spike=%b/%b done=%b/%b busy=%b/%b ready=%b/%b idx=%0d/%0d (actual/required)",
                 n, spike_valid, exp_valid, spike_out, exp_spike, window_done, exp_done, busy, m_run, smp_ready, exp_ready, step_idx, exp_idx);
      end
    end
  endtask

  initial begin
    for (int ch = 0; ch < NUM_CH; ch++) m_pix[ch] = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_rate();
    test_ttfs();
    test_stochastic();
    test_sparse();
    test_flush();
    test_reset_midframe();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
